// File: rtl/sd_block_responder.sv
// sd_block_responder: device end of the virtual-disk block handshake.
// Ports: sd_* host block bus, mount_* image announce, img_* byte image store.
module sd_block_responder #(
  parameter int IMG_AW    = 24,
  parameter int ACK_DELAY = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  input  logic              mount_req,
  input  logic [63:0]       mount_size,
  input  logic              mount_ro,
  output logic              img_mounted,
  output logic [63:0]       img_size,
  output logic              img_readonly,
  output logic [IMG_AW-1:0] img_addr,
  output logic              img_rd,
  input  logic [7:0]        img_rdata,
  output logic              img_wr,
  output logic [7:0]        img_wdata
);

  typedef enum logic [1:0] {
    IDLE, DELAY, XFER, DONE
  } state_t;

  localparam logic [9:0] DLY_LAST = 10'(ACK_DELAY - 1);

  state_t            state, state_nx;
  logic [9:0]        cnt, cnt_nx;
  logic              rearm;
  logic              op_rd;
  logic              rd_ok;
  logic              wr_ok;
  logic [IMG_AW-1:0] base;

  logic        req;
  logic        accept;
  logic [63:0] blk_start;
  logic [63:0] blk_end;
  logic        blk_ok;
  logic [8:0]  idx;
  logic        ph1;

  assign req       = sd_rd | sd_wr;
  assign accept    = (state == IDLE) && req && rearm;
  assign blk_start = {23'd0, sd_lba, 9'd0};
  assign blk_end   = blk_start + 64'd512;
  assign blk_ok    = (img_size != 64'd0) &&
                     (blk_end <= img_size);
  assign idx       = cnt[9:1];
  assign ph1       = cnt[0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rearm        <= 1'b1;
      op_rd        <= 1'b0;
      rd_ok        <= 1'b0;
      wr_ok        <= 1'b0;
      base         <= '0;
      sd_ack       <= 1'b0;
      img_mounted  <= 1'b0;
      img_size     <= '0;
      img_readonly <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      img_mounted <= mount_req;
      if (mount_req) begin
        img_size     <= mount_size;
        img_readonly <= mount_ro;
      end
      // validity is frozen here; a remount mid-transfer
      // does not change the block being served
      if (accept) begin
        rearm <= 1'b0;
        op_rd <= sd_rd;
        rd_ok <= blk_ok;
        wr_ok <= blk_ok & ~img_readonly;
        base  <= blk_start[IMG_AW-1:0];
      end else if (!req) begin
        rearm <= 1'b1;
      end
      if (state == DELAY && cnt == DLY_LAST)
        sd_ack <= 1'b1;
      else if (state == DONE)
        sd_ack <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = DELAY;
          cnt_nx   = '0;
        end
      end
      DELAY: begin
        if (cnt == DLY_LAST) begin
          state_nx = XFER;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      XFER: begin
        cnt_nx = cnt + 10'd1;
        if (cnt == 10'd1023)
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
    endcase
  end

  // two cycles per byte: phase0 addresses, phase1 moves data
  always_comb begin
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    sd_buff_wr   = 1'b0;
    img_addr     = '0;
    img_rd       = 1'b0;
    img_wr       = 1'b0;
    img_wdata    = '0;
    if (state == XFER) begin
      sd_buff_addr = idx;
      img_addr     = base + IMG_AW'(idx);
      if (op_rd) begin
        if (!ph1) begin
          img_rd = rd_ok;
        end else begin
          sd_buff_wr   = 1'b1;
          sd_buff_dout = rd_ok ? img_rdata : 8'h00;
        end
      end else if (ph1) begin
        img_wr    = wr_ok;
        img_wdata = sd_buff_din;
      end
    end
  end

endmodule
